// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner arbitration for the shared system bus.
// Ownership is held while the owner keeps its request up, so burst fills
// are never interleaved. Slave-side signals are muxed from the registered owner.
// Optional macro BUSARB_HOLD_LIMIT_EN: force a handover after HOLD_MAX owned
// cycles when another master is waiting.
module bus_arbiter #(
   parameter int NMASTERS = 2,
   parameter int HOLD_MAX = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NMASTERS-1:0]      m_req,
   output logic [NMASTERS-1:0]      m_ack,
   input  logic [NMASTERS-1:0]      m_rd,
   input  logic [NMASTERS-1:0]      m_wr,
   input  logic [32*NMASTERS-1:0]   m_addr,
   input  logic [32*NMASTERS-1:0]   m_wdata,
   output logic [NMASTERS-1:0]      m_ready,
   output logic [31:0]              m_rdata,
   output logic [31:0]              bus_addr,
   output logic [31:0]              bus_wdata,
   output logic                     bus_rd,
   output logic                     bus_wr,
   input  logic [31:0]              bus_rdata,
   input  logic                     bus_ready,
   output logic [2:0]               owner
);

   if (NMASTERS < 1 || NMASTERS > 8 || HOLD_MAX < 1 || HOLD_MAX > 128) begin : g_param_check
      $error("bus_arbiter: NMASTERS must be 1..8 and HOLD_MAX 1..128");
   end

   logic       own_valid_q, own_valid_d;
   logic [2:0] owner_q, owner_d;
   logic [2:0] last_q, last_d;
`ifdef BUSARB_HOLD_LIMIT_EN
   logic [6:0] hold_cnt_q, hold_cnt_d;
   logic       others;
`endif

   logic [7:0] req8;
   logic       keep;
   logic       force_rel;
   logic       found;
   logic [2:0] idx;
   logic [2:0] pick;

   // Zero-pad requests to the full 8-entry index space; missing masters never request.
   always_comb begin
      req8 = '0;
      req8[NMASTERS-1:0] = m_req;
   end

   // Next ownership: keep while the owner requests, otherwise round-robin search from last+1.
   always_comb begin
      own_valid_d = own_valid_q;
      owner_d     = owner_q;
      last_d      = last_q;
      found       = 1'b0;
      idx         = '0;
      pick        = '0;
      force_rel   = 1'b0;
      keep        = own_valid_q && req8[owner_q];
`ifdef BUSARB_HOLD_LIMIT_EN
      hold_cnt_d  = hold_cnt_q;
      others      = |(req8 & ~(8'd1 << owner_q));
      force_rel   = keep && others && (hold_cnt_q == 7'(HOLD_MAX - 1));
`endif
      if (keep && !force_rel) begin
`ifdef BUSARB_HOLD_LIMIT_EN
         // Saturate at the limit so a lone owner still hands over promptly once someone asks.
         if (hold_cnt_q != 7'(HOLD_MAX - 1))
            hold_cnt_d = hold_cnt_q + 7'd1;
`endif
      end else begin
         for (int k = 1; k <= NMASTERS; k++) begin
            idx = 3'((int'(last_q) + k) % NMASTERS);
            if (!found && req8[idx] && !(force_rel && idx == owner_q)) begin
               found = 1'b1;
               pick  = idx;
            end
         end
         if (found) begin
            own_valid_d = 1'b1;
            owner_d     = pick;
            last_d      = pick;
`ifdef BUSARB_HOLD_LIMIT_EN
            hold_cnt_d  = '0;
`endif
         end else begin
            own_valid_d = 1'b0;
         end
      end
   end

   // State registers; last starts at NMASTERS-1 so master 0 wins the first pick.
   always_ff @(posedge clk) begin
      if (rst) begin
         own_valid_q <= 1'b0;
         owner_q     <= '0;
         last_q      <= 3'(NMASTERS - 1);
`ifdef BUSARB_HOLD_LIMIT_EN
         hold_cnt_q  <= '0;
`endif
      end else begin
         own_valid_q <= own_valid_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
`ifdef BUSARB_HOLD_LIMIT_EN
         hold_cnt_q  <= hold_cnt_d;
`endif
      end
   end

   // Grant decode and slave-side mux from registered ownership; non-owners are invisible.
   always_comb begin
      m_ack     = '0;
      bus_addr  = '0;
      bus_wdata = '0;
      bus_rd    = 1'b0;
      bus_wr    = 1'b0;
      for (int i = 0; i < NMASTERS; i++) begin
         if (own_valid_q && owner_q == 3'(i)) begin
            m_ack[i]  = 1'b1;
            bus_addr  = m_addr[32*i +: 32];
            bus_wdata = m_wdata[32*i +: 32];
            bus_rd    = m_rd[i];
            bus_wr    = m_wr[i];
         end
      end
   end

   assign m_ready = m_ack & {NMASTERS{bus_ready}};
   assign m_rdata = bus_rdata;
   assign owner   = owner_q;

endmodule
